// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the per-button signals of the button conditioner.
//
//   master : owner of the raw button lines; observes conditioned outputs
//   slave  : the conditioner; samples raw lines, drives conditioned outputs
//
//   btn_raw    raw button levels, asynchronous to clk, 1 = pressed
//   btn_level  debounced button level
//   btn_re     one-cycle strobe on accepted press and on each auto-repeat
//   btn_fe     one-cycle strobe on accepted release
// ----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int unsigned N_BUTTONS = 2
);
    logic [N_BUTTONS-1:0] btn_raw;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_re;
    logic [N_BUTTONS-1:0] btn_fe;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_re,
        input  btn_fe
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_re,
        output btn_fe
    );
endinterface

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//   Per-button front end: two-flop synchronizer, debounce FSM and optional
//   hold-to-repeat for each of N_BUTTONS independent channels. Produces a
//   debounced level plus single-cycle press/release strobes, all registered.
//
//   Ports:
//     clk           system clock, rising edge
//     async_nreset  asynchronous active-low reset, clears all state
//     bus           button_conditioner_if.slave
//                     btn_raw   (in)  raw levels, 1 = pressed
//                     btn_level (out) debounced level
//                     btn_re    (out) press / auto-repeat strobe
//                     btn_fe    (out) release strobe
//
//   Parameters:
//     N_BUTTONS        number of channels (>=1)
//     DEBOUNCE_CYCLES  consecutive samples a new level must hold (>=1)
//     REPEAT_EN        1 = auto-repeat btn_re while held
//     REPEAT_DELAY     cycles from accepted press to first repeat (>=1)
//     REPEAT_PERIOD    cycles between subsequent repeats (>=1)
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned N_BUTTONS       = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    button_conditioner_if.slave  bus
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DLAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DONE    = DW'(1);
    localparam logic [RW-1:0] RDELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPERIOD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] RONE    = RW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    // Two-flop synchronizer; only the second stage (s) is used downstream.
    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] s;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
        state_e        state;
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt;
        // Set after the first repeat pulse so later pulses use REPEAT_PERIOD.
        logic          rep_seen;
        logic          level;
        logic          re;
        logic          fe;

        always_ff @(posedge clk or negedge async_nreset) begin
            if (!async_nreset) begin
                state    <= StIdle;
                dcnt     <= '0;
                rcnt     <= '0;
                rep_seen <= 1'b0;
                level    <= 1'b0;
                re       <= 1'b0;
                fe       <= 1'b0;
            end else begin
                re <= 1'b0;
                fe <= 1'b0;
                case (state)
                    StIdle: begin
                        if (s[i]) begin
                            if (DEBOUNCE_CYCLES <= 1) begin
                                state    <= StPressed;
                                dcnt     <= '0;
                                rcnt     <= '0;
                                rep_seen <= 1'b0;
                                level    <= 1'b1;
                                re       <= 1'b1;
                            end else begin
                                state <= StPressWait;
                                dcnt  <= DONE;
                            end
                        end
                    end

                    StPressWait: begin
                        if (!s[i]) begin
                            state <= StIdle;
                            dcnt  <= '0;
                        end else if (dcnt >= DLAST) begin
                            state    <= StPressed;
                            dcnt     <= '0;
                            rcnt     <= '0;
                            rep_seen <= 1'b0;
                            level    <= 1'b1;
                            re       <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DONE;
                        end
                    end

                    StPressed: begin
                        if (!s[i]) begin
                            rcnt     <= '0;
                            rep_seen <= 1'b0;
                            // With a one-sample debounce the release is accepted at once.
                            if (DEBOUNCE_CYCLES <= 1) begin
                                state <= StIdle;
                                dcnt  <= '0;
                                level <= 1'b0;
                                fe    <= 1'b1;
                            end else begin
                                state <= StReleaseWait;
                                dcnt  <= DONE;
                            end
                        end else if (REPEAT_EN != 0) begin
                            if ((rcnt + RONE) == (rep_seen ? RPERIOD : RDELAY)) begin
                                re       <= 1'b1;
                                rcnt     <= '0;
                                rep_seen <= 1'b1;
                            end else begin
                                rcnt <= rcnt + RONE;
                            end
                        end
                    end

                    StReleaseWait: begin
                        if (s[i]) begin
                            // Release bounce: back to held, no new press strobe.
                            state    <= StPressed;
                            dcnt     <= '0;
                            rcnt     <= '0;
                            rep_seen <= 1'b0;
                        end else if (dcnt >= DLAST) begin
                            state <= StIdle;
                            dcnt  <= '0;
                            level <= 1'b0;
                            fe    <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DONE;
                        end
                    end

                    default: begin
                        state <= StIdle;
                        dcnt  <= '0;
                    end
                endcase
            end
        end

        assign bus.btn_level[i] = level;
        assign bus.btn_re[i]    = re;
        assign bus.btn_fe[i]    = fe;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Per-button front end that turns raw, bouncy, asynchronous push-button inputs into clean single-cycle rising/falling-edge pulses and debounced levels.
- Produces the *_re strobes (e.g. next-segment and change-mode requests) consumed by the segment driver FSMs.
- Every button has an independent synchronizer, debounce FSM and counter, with optional hold-to-repeat on the rising-edge strobe.

Parameters:
- N_BUTTONS, 2, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples a new level must hold before it is accepted (>=1).
- REPEAT_EN, 0, 1 = enable auto-repeat of btn_re while a button is held.
- REPEAT_DELAY, 8, cycles after the accepted press before the first repeat pulse (>=1).
- REPEAT_PERIOD, 4, cycles between subsequent repeat pulses (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- async_nreset  input  1  asynchronous active-low reset.
- btn_raw  input  N_BUTTONS  raw button levels, asynchronous to clk, 1 = pressed.
- btn_level  output  N_BUTTONS  debounced button level, registered.
- btn_re  output  N_BUTTONS  one-cycle strobe on accepted press and on each auto-repeat, registered.
- btn_fe  output  N_BUTTONS  one-cycle strobe on accepted release, registered.

Behaviour:
- Reset state:
  - clk is the only clock; async_nreset is asynchronous and active-low. Assertion immediately clears all state regardless of clk.
  - On assertion: btn_level = 0, btn_re = 0, btn_fe = 0, both synchronizer stages = 0, every FSM = IDLE, all counters = 0.
- Synchronizer:
  - Two-flop synchronizer per bit. s[i] is the second stage.
  - Only s[i] feeds the FSM.
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. dcnt is the debounce counter, width clog2(DEBOUNCE_CYCLES+1).
  - IDLE: s=1 -> PRESS_WAIT, dcnt=1. If DEBOUNCE_CYCLES=1, go directly to PRESSED.
  - PRESS_WAIT: s=0 -> IDLE, dcnt=0. s=1 and dcnt=DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise dcnt+1.
  - On entry to PRESSED: btn_level <= 1, btn_re <= 1 for exactly one cycle, repeat counter rcnt = 0.
  - PRESSED: s=0 -> RELEASE_WAIT, dcnt=1. s=1 -> repeat logic runs.
  - RELEASE_WAIT: s=1 -> PRESSED with no btn_re, rcnt restarted at 0. s=0 and dcnt=DEBOUNCE_CYCLES-1 -> IDLE. Otherwise dcnt+1.
  - On entry to IDLE from RELEASE_WAIT: btn_level <= 0, btn_fe <= 1 for exactly one cycle.
- Latency:
  - Raw edge sampled by the first sync flop at edge k.
  - btn_level/btn_re (or btn_level/btn_fe) change at the output after edge k+DEBOUNCE_CYCLES+1, i.e. visible in cycle k+DEBOUNCE_CYCLES+2.
  - Bounce shorter than DEBOUNCE_CYCLES samples produces no output change.
- Auto-repeat (REPEAT_EN=1, PRESSED, s=1):
  - rcnt increments each cycle.
  - When rcnt reaches REPEAT_DELAY: btn_re pulses one cycle, rcnt reloads so the next pulse follows every REPEAT_PERIOD cycles.
  - Leaving PRESSED stops repeats immediately.
  - With REPEAT_EN=0, rcnt logic is inert and btn_re pulses only on entry from PRESS_WAIT/IDLE.
- Pulse and level rules:
  - btn_re and btn_fe are never high in the same cycle for one channel.
  - A pulse is never wider than one cycle. Consecutive repeat pulses are separated by at least REPEAT_PERIOD-1 low cycles.
  - btn_level stays 1 throughout PRESSED and RELEASE_WAIT.
- Channel independence: channels are fully independent; simultaneous presses on several buttons produce simultaneous strobes.
- Reset interactions:
  - Button held through reset release is treated as a fresh press: btn_re fires DEBOUNCE_CYCLES+2 cycles after release.
  - Reset asserted mid-debounce or mid-press returns to IDLE with no btn_fe emitted.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, btn_raw[0] 0->1 before edge 0, held -> btn_re[0] high only in cycle 6, btn_level[0] high from cycle 6 on, btn_fe stays 0.
- Bouncy press: btn_raw[0] toggles 1,0,1,0 each cycle, then stays 1 -> exactly one btn_re[0], emitted 6 cycles after the final rising edge. Release with 2-cycle glitches -> exactly one btn_fe[0].
- Short glitch: btn_raw[1] high for 3 cycles with DEBOUNCE_CYCLES=4 -> btn_level, btn_re, btn_fe all remain 0.
- Auto-repeat, REPEAT_EN=1, DELAY=8, PERIOD=4, hold 30 cycles -> btn_re[0] at cycle 6, then cycles 14, 18, 22, 26, 30, ... Release -> single btn_fe, no further btn_re.
- Simultaneous: both btn_raw bits rise in the same cycle -> btn_re = 2'b11 in the same single cycle, btn_level = 2'b11.
- Reset mid-press: assert async_nreset low while btn_level[0]=1 -> all outputs 0 immediately, no btn_fe. Release reset with button still held -> btn_re[0] pulse 6 cycles later.
